sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between the video_controller row preloader and a host port
//  used by the terminal/CPU side for single-word accesses.
//  Video bursts always win so the scanout line buffer is never starved. Host accesses fill idle time.
//  Sits between video_controller, the host logic and the SDRAM controller command interface.
// PARAMETERS
//  ADDR_WIDTH   23   word address width, shared by all ports
//  DATA_WIDTH   32   data word width
//  MAX_BURST    256  largest video burst issued; longer requests are clamped
//  HOST_TIMEOUT 1023 cycles in HOST_WAIT before aborting with host_error
// PORTS
//  clk                  in   1   system clock, all logic rising edge
//  reset_n              in   1   asynchronous active-low reset
//  vid_rd_request       in   1   one-cycle pulse: start video burst read
//  vid_rd_address       in   23  burst start address, sampled with the pulse
//  vid_rd_burst_length  in   9   words requested, sampled with the pulse
//  vid_rd_available     out  1   strobe: vid_rd_data holds a valid word
//  vid_rd_data          out  32  read word forwarded to the video controller
//  vid_overrun          out  1   sticky: a video pulse arrived while one was still pending
//  host_request         in   1   level; held high until host_ack or host_error
//  host_write           in   1   1 = write, 0 = read; stable while host_request is high
//  host_address         in   23  host word address
//  host_wr_data         in   32  host write data
//  host_rd_data         out  32  read result, valid in the host_ack cycle
//  host_ack             out  1   one-cycle pulse: host access complete
//  host_error           out  1   one-cycle pulse: host access timed out
//  sd_ready             in   1   SDRAM controller can accept a command
//  sd_request           out  1   one-cycle command strobe, issued only while sd_ready=1
//  sd_write             out  1   command type, valid with sd_request
//  sd_address           out  23  command address
//  sd_burst_length      out  9   words; always 1 for host accesses
//  sd_wr_data           out  32  write data, valid with sd_request
//  sd_available         in   1   read word strobe from the controller
//  sd_rd_data           in   32  read word
//  sd_done              in   1   pulse: command fully complete
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, every output 0, pending flag and all counters cleared.
//  Video latch: a vid_rd_request pulse sets vid_pending and captures the address.
//   It also captures min(len, MAX_BURST). This happens in any state.
//   A pulse while vid_pending=1 overwrites the capture and sets vid_overrun.
//   vid_overrun is cleared only by reset.
//  FSM states: IDLE, VID_ISSUE, VID_BURST, HOST_ISSUE, HOST_WAIT.
//  IDLE:
//   vid_pending, len=0: clear pending, stay IDLE, no SDRAM command.
//   vid_pending, len>0: go to VID_ISSUE.
//   Otherwise host_request: go to HOST_ISSUE.
//   Video has strict priority when both are present in the same cycle.
//  VID_ISSUE: when sd_ready=1, drive sd_request=1 for one cycle.
//   Same cycle: sd_write=0, captured address and length on sd_*. Clear vid_pending; go to VID_BURST.
//  VID_BURST:
//   Each sd_available is forwarded one cycle later as vid_rd_available/vid_rd_data (registered).
//   A word counter counts the returned words.
//   Leave when counter == length or on sd_done, whichever comes first; go to IDLE.
//   Extra sd_available strobes after that are dropped.
//  HOST_ISSUE: when sd_ready=1, drive sd_request=1 with burst_length=1, sd_write=host_write.
//   Same cycle: host address and data. Then go to HOST_WAIT and clear the timeout counter.
//  HOST_WAIT:
//   On a read, the sd_available word is captured into host_rd_data.
//   On sd_done: pulse host_ack, go to IDLE.
//   A read ending with sd_done and no sd_available returns 0.
//   Timeout counter reaches HOST_TIMEOUT: pulse host_error, go to IDLE.
//  Host handshake:
//   After host_ack, the arbiter ignores host_request for one cycle so the requester can drop it.
//   No duplicate access is issued.
//  A video pulse during a host access is latched and served directly after it. Host accesses never pre-empt.
//  Latency, IDLE with sd_ready=1: video pulse at cycle N -> sd_request at N+2.
//   Host request at N -> sd_request at N+2.
//  sd_request is never asserted when sd_ready=0 or outside the *_ISSUE states.
//  Reset mid-burst: outputs drop at once. The pending burst is discarded and not replayed.
// TESTING
//  1. Video pulse, addr=0x200, len=40; controller returns 40 words ->
//     one sd_request (burst 40), 40 vid_rd_available strobes with data in order, FSM back to IDLE.
//  2. Host read and video pulse in the same cycle ->
//     video command issued first; host sd_request only after the video burst; host_ack once.
//  3. Host write to 0x7FFFFF, data 0xDEADBEEF, sd_ready held low 5 cycles ->
//     sd_request in the first cycle sd_ready=1, sd_write=1, host_ack after sd_done.
//  4. Two video pulses 3 cycles apart during a host access ->
//     vid_overrun=1; only the second address is burst.
//  5. Video len=0 -> no SDRAM command.
//     len=300 -> sd_burst_length=256.
//  6. Host read, sd_done never arrives -> host_error after 1023 cycles, FSM in IDLE.
//     Then assert reset_n=0 mid-video-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the video, host and SDRAM-command signals around the port arbiter.
// The arbiter takes the master view; the surrounding logic (or a bench) takes the slave view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32,
  parameter int BLEN_WIDTH = 9
);
  logic                  vid_rd_request;
  logic [ADDR_WIDTH-1:0] vid_rd_address;
  logic [BLEN_WIDTH-1:0] vid_rd_burst_length;
  logic                  vid_rd_available;
  logic [DATA_WIDTH-1:0] vid_rd_data;
  logic                  vid_overrun;

  logic                  host_request;
  logic                  host_write;
  logic [ADDR_WIDTH-1:0] host_address;
  logic [DATA_WIDTH-1:0] host_wr_data;
  logic [DATA_WIDTH-1:0] host_rd_data;
  logic                  host_ack;
  logic                  host_error;

  logic                  sd_ready;
  logic                  sd_request;
  logic                  sd_write;
  logic [ADDR_WIDTH-1:0] sd_address;
  logic [BLEN_WIDTH-1:0] sd_burst_length;
  logic [DATA_WIDTH-1:0] sd_wr_data;
  logic                  sd_available;
  logic [DATA_WIDTH-1:0] sd_rd_data;
  logic                  sd_done;

  modport master (
    input  vid_rd_request, vid_rd_address, vid_rd_burst_length,
    output vid_rd_available, vid_rd_data, vid_overrun,
    input  host_request, host_write, host_address, host_wr_data,
    output host_rd_data, host_ack, host_error,
    input  sd_ready, sd_available, sd_rd_data, sd_done,
    output sd_request, sd_write, sd_address, sd_burst_length, sd_wr_data
  );

  modport slave (
    output vid_rd_request, vid_rd_address, vid_rd_burst_length,
    input  vid_rd_available, vid_rd_data, vid_overrun,
    output host_request, host_write, host_address, host_wr_data,
    input  host_rd_data, host_ack, host_error,
    output sd_ready, sd_available, sd_rd_data, sd_done,
    input  sd_request, sd_write, sd_address, sd_burst_length, sd_wr_data
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between video burst reads (strict priority)
// and single-word host accesses that fill the idle time.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH   = 23,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 256,
  parameter int HOST_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sdram_port_arbiter_if.master bus
);
  localparam int BLW = 9;
  localparam int TW  = $clog2(HOST_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, VID_ISSUE, VID_BURST, HOST_ISSUE, HOST_WAIT} state_t;

  state_t                r_state, w_next;
  logic                  r_vid_pending, r_overrun;
  logic [ADDR_WIDTH-1:0] r_vid_addr;
  logic [BLW-1:0]        r_vid_len, r_cur_len, r_wcnt;
  logic                  r_vid_avail;
  logic [DATA_WIDTH-1:0] r_vid_data;
  logic                  r_host_req, r_host_ack, r_host_err;
  logic [DATA_WIDTH-1:0] r_host_rd;
  logic [TW-1:0]         r_tmo;

  logic                  w_issue, w_vid_issue, w_host_issue, w_vid_drop;
  logic                  w_ack_set, w_err_set, w_fwd;
  logic [BLW-1:0]        w_req_len, w_wcnt_inc;

  assign w_req_len    = (bus.vid_rd_burst_length > BLW'(MAX_BURST)) ? BLW'(MAX_BURST)
                                                                     : bus.vid_rd_burst_length;
  assign w_wcnt_inc   = r_wcnt + 1'b1;
  assign w_vid_issue  = w_issue && (r_state == VID_ISSUE);
  assign w_host_issue = w_issue && (r_state == HOST_ISSUE);
  assign w_fwd        = (r_state == VID_BURST) && bus.sd_available;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_vid_drop = 1'b0;
    w_ack_set  = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_vid_pending) begin
          if (r_vid_len == '0) w_vid_drop = 1'b1;
          else                 w_next     = VID_ISSUE;
        end else if (r_host_req) begin
          w_next = HOST_ISSUE;
        end
      end
      VID_ISSUE: if (bus.sd_ready) begin
        w_issue = 1'b1;
        w_next  = VID_BURST;
      end
      VID_BURST: if (bus.sd_done || (bus.sd_available && (w_wcnt_inc == r_cur_len)))
        w_next = IDLE;
      HOST_ISSUE: if (bus.sd_ready) begin
        w_issue = 1'b1;
        w_next  = HOST_WAIT;
      end
      HOST_WAIT: begin
        if (bus.sd_done) begin
          w_ack_set = 1'b1;
          w_next    = IDLE;
        end else if (r_tmo == TW'(HOST_TIMEOUT - 1)) begin
          w_err_set = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Command fields are zero whenever no command is strobed.
  assign bus.sd_request      = w_issue;
  assign bus.sd_write        = w_host_issue && bus.host_write;
  assign bus.sd_address      = w_vid_issue ? r_vid_addr : (w_host_issue ? bus.host_address : '0);
  assign bus.sd_burst_length = w_vid_issue ? r_vid_len  : (w_host_issue ? BLW'(1) : '0);
  assign bus.sd_wr_data      = w_host_issue ? bus.host_wr_data : '0;

  // A new pulse always wins over the clear, so a pulse in the issue cycle stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_pending <= 1'b0;
      r_vid_addr    <= '0;
      r_vid_len     <= '0;
      r_overrun     <= 1'b0;
    end else if (bus.vid_rd_request) begin
      r_vid_pending <= 1'b1;
      r_vid_addr    <= bus.vid_rd_address;
      r_vid_len     <= w_req_len;
      if (r_vid_pending) r_overrun <= 1'b1;
    end else if (w_vid_drop || w_vid_issue) begin
      r_vid_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_len   <= '0;
      r_wcnt      <= '0;
      r_vid_avail <= 1'b0;
      r_vid_data  <= '0;
    end else begin
      r_vid_avail <= w_fwd;
      if (w_fwd) r_vid_data <= bus.sd_rd_data;
      if (w_vid_issue) begin
        r_cur_len <= r_vid_len;
        r_wcnt    <= '0;
      end else if (w_fwd) begin
        r_wcnt <= w_wcnt_inc;
      end
    end
  end

  // host_request is registered, so its stale copy is masked for the two cycles
  // around ack/error while the requester drops the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_host_req <= 1'b0;
      r_host_ack <= 1'b0;
      r_host_err <= 1'b0;
      r_host_rd  <= '0;
      r_tmo      <= '0;
    end else begin
      r_host_req <= bus.host_request && !(w_ack_set || w_err_set || r_host_ack || r_host_err);
      r_host_ack <= w_ack_set;
      r_host_err <= w_err_set;
      if (w_host_issue) begin
        r_host_rd <= '0;
        r_tmo     <= '0;
      end else if (r_state == HOST_WAIT) begin
        r_tmo <= r_tmo + 1'b1;
        if (bus.sd_available && !bus.host_write) r_host_rd <= bus.sd_rd_data;
      end
    end
  end

  assign bus.vid_rd_available = r_vid_avail;
  assign bus.vid_rd_data      = r_vid_data;
  assign bus.vid_overrun      = r_overrun;
  assign bus.host_rd_data     = r_host_rd;
  assign bus.host_ack         = r_host_ack;
  assign bus.host_error       = r_host_err;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a small SDRAM controller model answers commands,
// a monitor logs command/strobe/ack events, and each test task checks them against hand values.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  initial forever #5 clk = ~clk;

  sdram_port_arbiter_if bus_if ();
  sdram_port_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ctl_delay = 0;
  bit ctl_mute = 1'b0;

  logic [22:0] req_addr[$];
  int          req_len[$];
  logic        req_wr[$];
  logic [31:0] req_wdata[$];
  int          req_cyc[$];
  logic [31:0] vid_q[$];
  int ack_cnt = 0, err_cnt = 0, ack_cyc = 0, err_cyc = 0, viol = 0;
  logic [31:0] ack_data = '0;

  logic [133:0] outs;
  assign outs = {bus_if.vid_rd_available, bus_if.vid_rd_data, bus_if.vid_overrun,
                 bus_if.host_rd_data, bus_if.host_ack, bus_if.host_error,
                 bus_if.sd_request, bus_if.sd_write, bus_if.sd_address,
                 bus_if.sd_burst_length, bus_if.sd_wr_data};

  function automatic logic [31:0] dpat(input logic [22:0] a, input int i);
    return {a[15:0], 16'(i)} ^ 32'h5A5A_0000;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // controller model: answers each command ctl_delay+2 cycles later, sd_done on the last word
  initial begin
    logic [22:0] a;
    int          l;
    logic        w;
    bus_if.sd_available = 1'b0;
    bus_if.sd_done      = 1'b0;
    bus_if.sd_rd_data   = '0;
    forever begin
      @(negedge clk);
      if (bus_if.sd_request === 1'b1 && !ctl_mute) begin
        a = bus_if.sd_address;
        l = int'(bus_if.sd_burst_length);
        w = bus_if.sd_write;
        repeat (2 + ctl_delay) @(posedge clk);
        #1;
        for (int i = 0; i < l; i++) begin
          bus_if.sd_available = !w;
          bus_if.sd_rd_data   = w ? 32'h0 : dpat(a, i);
          bus_if.sd_done      = (i == l - 1);
          @(posedge clk);
          #1;
        end
        bus_if.sd_available = 1'b0;
        bus_if.sd_done      = 1'b0;
        bus_if.sd_rd_data   = '0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus_if.sd_request === 1'b1) begin
      req_addr.push_back(bus_if.sd_address);
      req_len.push_back(int'(bus_if.sd_burst_length));
      req_wr.push_back(bus_if.sd_write);
      req_wdata.push_back(bus_if.sd_wr_data);
      req_cyc.push_back(cyc);
      if (bus_if.sd_ready !== 1'b1) viol++;
    end
    if (bus_if.vid_rd_available === 1'b1) vid_q.push_back(bus_if.vid_rd_data);
    if (bus_if.host_ack === 1'b1) begin
      ack_cnt++;
      ack_cyc  = cyc;
      ack_data = bus_if.host_rd_data;
    end
    if (bus_if.host_error === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    req_addr.delete(); req_len.delete(); req_wr.delete();
    req_wdata.delete(); req_cyc.delete(); vid_q.delete();
  endtask

  task automatic vid_pulse(input logic [22:0] a, input logic [8:0] l);
    bus_if.vid_rd_request      = 1'b1;
    bus_if.vid_rd_address      = a;
    bus_if.vid_rd_burst_length = l;
    tick(1);
    bus_if.vid_rd_request = 1'b0;
  endtask

  task automatic host_go(input logic wr, input logic [22:0] a, input logic [31:0] d);
    bus_if.host_request = 1'b1;
    bus_if.host_write   = wr;
    bus_if.host_address = a;
    bus_if.host_wr_data = d;
  endtask

  task automatic host_finish(input int a0, input int e0, input int budget);
    for (int k = 0; k < budget && ack_cnt == a0 && err_cnt == e0; k++) tick(1);
    bus_if.host_request = 1'b0;
  endtask

  task automatic wait_vid(input int n, input int budget);
    for (int k = 0; k < budget && !(vid_q.size() >= n && dut.r_state == 3'd0); k++) tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus_if.vid_rd_request = 0; bus_if.vid_rd_address = '0; bus_if.vid_rd_burst_length = '0;
    bus_if.host_request = 0; bus_if.host_write = 0; bus_if.host_address = '0;
    bus_if.host_wr_data = '0; bus_if.sd_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if (outs !== '0) begin n_errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    n_checks++; if (dut.r_state !== 3'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", dut.r_state); end
    tick(2);
    reset_n = 1'b1;
    tick(3);
    n_checks++; if (req_addr.size() != 0) begin n_errors++; $display("FAIL reset_idle_req got %0d exp 0", req_addr.size()); end
  endtask

  task automatic test_video_burst();
    int n;
    clr();
    n = cyc;
    vid_pulse(23'h200, 9'd40);
    wait_vid(40, 200);
    n_checks++; if (req_addr.size() != 1) begin n_errors++; $display("FAIL t1_nreq got %0d exp 1", req_addr.size()); end
    n_checks++; if (req_addr[0] !== 23'h200) begin n_errors++; $display("FAIL t1_addr got %h exp 200", req_addr[0]); end
    n_checks++; if (req_len[0] != 40) begin n_errors++; $display("FAIL t1_len got %0d exp 40", req_len[0]); end
    n_checks++; if (req_wr[0] !== 1'b0) begin n_errors++; $display("FAIL t1_wr got %b exp 0", req_wr[0]); end
    n_checks++; if (req_cyc[0] != n + 2) begin n_errors++; $display("FAIL t1_latency got %0d exp %0d", req_cyc[0], n + 2); end
    n_checks++; if (vid_q.size() != 40) begin n_errors++; $display("FAIL t1_nwords got %0d exp 40", vid_q.size()); end
    for (int i = 0; i < 40 && i < vid_q.size(); i++) begin
      n_checks++;
      if (vid_q[i] !== dpat(23'h200, i)) begin n_errors++; $display("FAIL t1_data[%0d] got %h exp %h", i, vid_q[i], dpat(23'h200, i)); end
    end
    n_checks++; if (dut.r_state !== 3'd0) begin n_errors++; $display("FAIL t1_idle got %0d exp 0", dut.r_state); end
    n_checks++; if (bus_if.vid_overrun !== 1'b0) begin n_errors++; $display("FAIL t1_overrun got %b exp 0", bus_if.vid_overrun); end
  endtask

  task automatic test_priority();
    int n, a0, e0;
    clr();
    a0 = ack_cnt; e0 = err_cnt; n = cyc;
    host_go(1'b0, 23'h1234, 32'h0);
    vid_pulse(23'h400, 9'd4);
    host_finish(a0, e0, 100);
    tick(10);
    n_checks++; if (req_addr.size() != 2) begin n_errors++; $display("FAIL t2_nreq got %0d exp 2", req_addr.size()); end
    n_checks++; if (req_addr[0] !== 23'h400 || req_len[0] != 4) begin n_errors++; $display("FAIL t2_first got %h/%0d exp 400/4", req_addr[0], req_len[0]); end
    n_checks++; if (req_addr[1] !== 23'h1234 || req_len[1] != 1 || req_wr[1] !== 1'b0) begin n_errors++; $display("FAIL t2_host_cmd got %h/%0d/%b exp 1234/1/0", req_addr[1], req_len[1], req_wr[1]); end
    n_checks++; if (req_cyc[1] != n + 9) begin n_errors++; $display("FAIL t2_host_cyc got %0d exp %0d", req_cyc[1], n + 9); end
    n_checks++; if (vid_q.size() != 4) begin n_errors++; $display("FAIL t2_nwords got %0d exp 4", vid_q.size()); end
    n_checks++; if (ack_cnt - a0 != 1) begin n_errors++; $display("FAIL t2_acks got %0d exp 1", ack_cnt - a0); end
    n_checks++; if (ack_data !== dpat(23'h1234, 0)) begin n_errors++; $display("FAIL t2_rd_data got %h exp %h", ack_data, dpat(23'h1234, 0)); end
  endtask

  task automatic test_host_write();
    int n, a0, e0;
    clr();
    a0 = ack_cnt; e0 = err_cnt; n = cyc;
    bus_if.sd_ready = 1'b0;
    host_go(1'b1, 23'h7FFFFF, 32'hDEADBEEF);
    tick(5);
    bus_if.sd_ready = 1'b1;
    host_finish(a0, e0, 100);
    tick(4);
    n_checks++; if (req_addr.size() != 1) begin n_errors++; $display("FAIL t3_nreq got %0d exp 1", req_addr.size()); end
    n_checks++; if (req_cyc[0] != n + 5) begin n_errors++; $display("FAIL t3_req_cyc got %0d exp %0d", req_cyc[0], n + 5); end
    n_checks++; if (req_wr[0] !== 1'b1 || req_addr[0] !== 23'h7FFFFF) begin n_errors++; $display("FAIL t3_cmd got %b/%h exp 1/7fffff", req_wr[0], req_addr[0]); end
    n_checks++; if (req_wdata[0] !== 32'hDEADBEEF || req_len[0] != 1) begin n_errors++; $display("FAIL t3_wdata got %h/%0d exp deadbeef/1", req_wdata[0], req_len[0]); end
    n_checks++; if (ack_cnt - a0 != 1 || ack_cyc != n + 8) begin n_errors++; $display("FAIL t3_ack got %0d@%0d exp 1@%0d", ack_cnt - a0, ack_cyc, n + 8); end
  endtask

  task automatic test_overrun();
    int a0, e0;
    clr();
    a0 = ack_cnt; e0 = err_cnt;
    ctl_delay = 10;
    host_go(1'b0, 23'h0AB0, 32'h0);
    tick(3);
    vid_pulse(23'h300, 9'd2);
    n_checks++; if (bus_if.vid_overrun !== 1'b0) begin n_errors++; $display("FAIL t4_ovr_first got %b exp 0", bus_if.vid_overrun); end
    tick(2);
    vid_pulse(23'h500, 9'd3);
    n_checks++; if (bus_if.vid_overrun !== 1'b1) begin n_errors++; $display("FAIL t4_ovr_second got %b exp 1", bus_if.vid_overrun); end
    host_finish(a0, e0, 100);
    ctl_delay = 0;
    wait_vid(3, 100);
    tick(5);
    n_checks++; if (req_addr.size() != 2) begin n_errors++; $display("FAIL t4_nreq got %0d exp 2", req_addr.size()); end
    n_checks++; if (req_addr[1] !== 23'h500 || req_len[1] != 3) begin n_errors++; $display("FAIL t4_vid_cmd got %h/%0d exp 500/3", req_addr[1], req_len[1]); end
    n_checks++; if (vid_q.size() != 3 || vid_q[2] !== dpat(23'h500, 2)) begin n_errors++; $display("FAIL t4_words got %0d/%h exp 3/%h", vid_q.size(), vid_q[2], dpat(23'h500, 2)); end
    n_checks++; if (ack_data !== dpat(23'h0AB0, 0)) begin n_errors++; $display("FAIL t4_rd_data got %h exp %h", ack_data, dpat(23'h0AB0, 0)); end
  endtask

  task automatic test_len_bounds();
    clr();
    vid_pulse(23'h0F0, 9'd0);
    tick(8);
    n_checks++; if (req_addr.size() != 0) begin n_errors++; $display("FAIL t5_len0_req got %0d exp 0", req_addr.size()); end
    n_checks++; if (dut.r_state !== 3'd0) begin n_errors++; $display("FAIL t5_len0_idle got %0d exp 0", dut.r_state); end
    vid_pulse(23'h1000, 9'd300);
    wait_vid(256, 600);
    tick(5);
    n_checks++; if (req_len[0] != 256) begin n_errors++; $display("FAIL t5_clamp got %0d exp 256", req_len[0]); end
    n_checks++; if (vid_q.size() != 256) begin n_errors++; $display("FAIL t5_nwords got %0d exp 256", vid_q.size()); end
    n_checks++; if (vid_q[255] !== dpat(23'h1000, 255)) begin n_errors++; $display("FAIL t5_last got %h exp %h", vid_q[255], dpat(23'h1000, 255)); end
  endtask

  task automatic test_timeout_reset();
    int n, a0, e0, nv;
    clr();
    a0 = ack_cnt; e0 = err_cnt; n = cyc;
    ctl_mute = 1'b1;
    host_go(1'b0, 23'h0042, 32'h0);
    host_finish(a0, e0, 1200);
    ctl_mute = 1'b0;
    n_checks++; if (req_cyc[0] != n + 2) begin n_errors++; $display("FAIL t6_host_latency got %0d exp %0d", req_cyc[0], n + 2); end
    n_checks++; if (err_cnt - e0 != 1) begin n_errors++; $display("FAIL t6_errors got %0d exp 1", err_cnt - e0); end
    n_checks++; if (err_cyc != req_cyc[0] + 1024) begin n_errors++; $display("FAIL t6_err_cyc got %0d exp %0d", err_cyc, req_cyc[0] + 1024); end
    n_checks++; if (ack_cnt != a0) begin n_errors++; $display("FAIL t6_no_ack got %0d exp %0d", ack_cnt, a0); end
    n_checks++; if (dut.r_state !== 3'd0) begin n_errors++; $display("FAIL t6_idle got %0d exp 0", dut.r_state); end
    tick(3);
    clr();
    vid_pulse(23'h800, 9'd40);
    for (int k = 0; k < 100 && vid_q.size() < 10; k++) tick(1);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (outs !== '0) begin n_errors++; $display("FAIL t6_reset_outs got %h exp 0", outs); end
    nv = vid_q.size();
    tick(3);
    reset_n = 1'b1;
    tick(60);
    n_checks++; if (req_addr.size() != 1) begin n_errors++; $display("FAIL t6_no_replay got %0d exp 1", req_addr.size()); end
    n_checks++; if (vid_q.size() != nv) begin n_errors++; $display("FAIL t6_dropped_words got %0d exp %0d", vid_q.size(), nv); end
    n_checks++; if (viol != 0) begin n_errors++; $display("FAIL sd_ready_rule got %0d exp 0", viol); end
  endtask

  initial begin
    test_reset();
    test_video_burst();
    test_priority();
    test_host_write();
    test_overrun();
    test_len_bounds();
    test_timeout_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
